// File: rtl/binary_mul_pkg.sv
// rtl/binary_mul_pkg.sv - shared states and mode constants for the sequential multiplier
package binary_mul_pkg;

  localparam int MODE_UNSIGNED = 0;
  localparam int MODE_SIGNED   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must be able to hold W itself, hence W+1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/binary_mul_step.sv
// rtl/binary_mul_step.sv - one combinational multiply iteration (Booth or shift-add) plus shift
module binary_mul_step
  import binary_mul_pkg::*;
#(
  parameter int W           = 6,
  parameter int SIGNED_MODE = MODE_SIGNED
) (
  input  logic [W:0]   acc,
  input  logic [W-1:0] q,
  input  logic         q_m1,
  input  logic [W-1:0] a,
  output logic [W:0]   acc_nxt,
  output logic [W-1:0] q_nxt,
  output logic         q_m1_nxt
);

  logic [W:0] a_ext;
  logic [W:0] sum;
  logic       fill;

  always_comb begin
    a_ext = '0;
    sum   = acc;
    fill  = 1'b0;
    if (SIGNED_MODE == MODE_SIGNED) begin
      // One guard bit lets -2^(W-1) be negated without overflow.
      a_ext = {a[W-1], a};
      unique case ({q[0], q_m1})
        2'b01:   sum = acc + a_ext;
        2'b10:   sum = acc - a_ext;
        default: sum = acc;
      endcase
      fill = sum[W];
    end else begin
      a_ext = {1'b0, a};
      if (q[0]) sum = acc + a_ext;
      fill = 1'b0;
    end
    acc_nxt  = {fill, sum[W:1]};
    q_nxt    = {sum[0], q[W-1:1]};
    q_m1_nxt = q[0];
  end

endmodule

// File: rtl/binary_mul_seq.sv
// rtl/binary_mul_seq.sv - sequential W x W multiplier with valid/ready handshakes
module binary_mul_seq
  import binary_mul_pkg::*;
#(
  parameter int W           = 6,
  parameter int SIGNED_MODE = MODE_SIGNED
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] P,
  output logic           busy
);

  localparam int             CW   = cnt_width(W);
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_reg;
  logic [W:0]    acc;
  logic [W-1:0]  q;
  logic          q_m1;

  logic [W:0]    acc_nxt;
  logic [W-1:0]  q_nxt;
  logic          q_m1_nxt;
  logic          accept;
  logic          last_iter;

  binary_mul_step #(
    .W           (W),
    .SIGNED_MODE (SIGNED_MODE)
  ) u_step (
    .acc      (acc),
    .q        (q),
    .q_m1     (q_m1),
    .a        (a_reg),
    .acc_nxt  (acc_nxt),
    .q_nxt    (q_nxt),
    .q_m1_nxt (q_m1_nxt)
  );

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);
  assign accept    = en && in_valid && in_ready;
  assign last_iter = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      unique case (state)
        IDLE:    if (accept) state_nxt = CALC;
        CALC:    if (last_iter) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = in_valid ? CALC : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Product register keeps its value through IDLE until the next DONE load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_reg <= '0;
      acc   <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      P     <= '0;
    end else if (en) begin
      if (accept) begin
        a_reg <= A;
        q     <= B;
        acc   <= '0;
        q_m1  <= 1'b0;
        cnt   <= '0;
      end else if (state == CALC) begin
        acc  <= acc_nxt;
        q    <= q_nxt;
        q_m1 <= q_m1_nxt;
        cnt  <= cnt + CW'(1);
        if (last_iter) P <= {acc_nxt[W-1:0], q_nxt};
      end
    end
  end

endmodule

// File: tb/tb_binary_mul_seq.sv
// tb/tb_binary_mul_seq.sv - scoreboard bench for signed/unsigned W=6 and signed W=16 multipliers
module tb_binary_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n, en, in_valid, out_ready;
  logic [15:0] a_in, b_in;
  logic [1:0]  sel;

  logic        s6_in_ready, s6_out_valid, s6_busy;
  logic [11:0] s6_p;
  logic        u6_in_ready, u6_out_valid, u6_busy;
  logic [11:0] u6_p;
  logic        s16_in_ready, s16_out_valid, s16_busy;
  logic [31:0] s16_p;

  logic        m_in_ready, m_out_valid, m_busy;
  logic [31:0] m_p;

  typedef struct {
    int          a;
    int          b;
    logic [31:0] p;
  } vec_t;

  logic [31:0] exp_q[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  binary_mul_seq #(.W(6), .SIGNED_MODE(1)) dut_s6 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid && (sel == 2'd0)),
    .in_ready(s6_in_ready), .A(a_in[5:0]), .B(b_in[5:0]), .out_valid(s6_out_valid),
    .out_ready(out_ready), .P(s6_p), .busy(s6_busy)
  );

  binary_mul_seq #(.W(6), .SIGNED_MODE(0)) dut_u6 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid && (sel == 2'd1)),
    .in_ready(u6_in_ready), .A(a_in[5:0]), .B(b_in[5:0]), .out_valid(u6_out_valid),
    .out_ready(out_ready), .P(u6_p), .busy(u6_busy)
  );

  binary_mul_seq #(.W(16), .SIGNED_MODE(1)) dut_s16 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid && (sel == 2'd2)),
    .in_ready(s16_in_ready), .A(a_in), .B(b_in), .out_valid(s16_out_valid),
    .out_ready(out_ready), .P(s16_p), .busy(s16_busy)
  );

  always_comb begin
    m_in_ready  = s6_in_ready;
    m_out_valid = s6_out_valid;
    m_busy      = s6_busy;
    m_p         = {20'd0, s6_p};
    if (sel == 2'd1) begin
      m_in_ready = u6_in_ready; m_out_valid = u6_out_valid; m_busy = u6_busy; m_p = {20'd0, u6_p};
    end else if (sel == 2'd2) begin
      m_in_ready = s16_in_ready; m_out_valid = s16_out_valid; m_busy = s16_busy; m_p = s16_p;
    end
  end

  function automatic logic [31:0] pm(input longint v, input int bits);
    longint m;
    m = (longint'(1) << bits) - 1;
    return 32'(v & m);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_mis++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Handshake completes on the next edge when both sides are high at the falling edge.
  always @(negedge clk) begin
    if (rst_n && en && m_out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_product", m_p, 32'hDEADBEEF);
      end else begin
        check("product", m_p, exp_q.pop_front());
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input int a, input int b, input logic [31:0] exp);
    bit ok;
    ok = 1'b0;
    a_in = 16'(a);
    b_in = 16'(b);
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_in_ready && en && rst_n) begin
        exp_q.push_back(exp);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("send_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_latency(input int a, input int b, input logic [31:0] exp,
                             input int stall_at, input int stall_len, output int n);
    n = -1;
    send(a, b, exp);
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == stall_at) en = 1'b0;
      if (i == stall_at + 2) check("stall_busy", 32'(m_busy), 32'd1);
      if (i == stall_at + stall_len) en = 1'b1;
      if (m_out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    vec_t tab[8];
    int   n;
    int   seen;
    logic [31:0] held;

    tab[0] = '{a: -32, b: -32, p: 32'h400};
    tab[1] = '{a:  31, b: -32, p: 32'hC20};
    tab[2] = '{a:   0, b:   0, p: 32'h000};
    tab[3] = '{a:  -1, b:  -1, p: 32'h001};
    tab[4] = '{a:   5, b:  -7, p: 32'hFDD};
    tab[5] = '{a:  31, b:  31, p: 32'h3C1};
    tab[6] = '{a: -32, b:  31, p: 32'hC20};
    tab[7] = '{a:   1, b: -32, p: 32'hFE0};

    rst_n = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = 2'd0;
    a_in = '0; b_in = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(m_in_ready), 32'd1);
    check("rst_out_valid", 32'(m_out_valid), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_p", m_p, 32'd0);
    check("rst_p_u6", {20'd0, u6_p}, 32'd0);
    check("rst_p_s16", s16_p, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) send(tab[i].a, tab[i].b, tab[i].p);
    wait_drain();

    for (int a = -32; a <= 31; a++)
      for (int b = -32; b <= 31; b++)
        send(a, b, pm(longint'(a * b), 12));
    wait_drain();

    run_latency(5, 6, pm(30, 12), 0, 0, n);
    check("latency_w6", 32'(n), 32'd6);
    wait_drain();

    pop_cyc.delete();
    for (int k = 0; k < 4; k++) send(k + 3, -(k + 1), pm(longint'((k + 3) * -(k + 1)), 12));
    wait_drain();
    check("b2b_count", 32'(pop_cyc.size()), 32'd4);
    if (pop_cyc.size() == 4)
      for (int i = 0; i < 3; i++) check("b2b_period", 32'(pop_cyc[i+1] - pop_cyc[i]), 32'd7);

    out_ready = 1'b0;
    send(7, -3, pm(-21, 12));
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_out_valid) begin seen = 1; break; end
    end
    if (seen == 0) fail_now("bp_wait");
    held = m_p;
    check("bp_p", held, pm(-21, 12));
    check("bp_in_ready", 32'(m_in_ready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(m_out_valid), 32'd1);
      check("bp_hold_p", m_p, held);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();
    check("retain_valid", 32'(m_out_valid), 32'd0);
    check("retain_p", m_p, pm(-21, 12));

    run_latency(9, -4, pm(-36, 12), 2, 5, n);
    check("latency_stall", 32'(n), 32'd11);
    wait_drain();

    send(5, -7, pm(-35, 12));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_p", m_p, 32'd0);
    check("midrst_valid", 32'(m_out_valid), 32'd0);
    check("midrst_busy", 32'(m_busy), 32'd0);
    check("midrst_in_ready", 32'(m_in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_out_valid) seen++;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    send(3, 3, 32'd9);
    wait_drain();

    sel = 2'd1;
    send(63, 63, 32'hF81);
    send(0, 63, 32'd0);
    send(32, 2, 32'd64);
    for (int a = 0; a <= 63; a++)
      for (int b = 0; b <= 63; b++)
        send(a, b, pm(longint'(a * b), 12));
    wait_drain();

    sel = 2'd2;
    run_latency(-32768, -32768, 32'h40000000, 0, 0, n);
    check("latency_w16", 32'(n), 32'd16);
    wait_drain();
    send(32767, -32768, pm(longint'(32767) * -32768, 32));
    send(-1, -1, 32'd1);
    send(-300, 211, pm(-63300, 32));
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
